// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared state encoding and grant type for the AES stream arbiter
package aes_arb_pkg;
  localparam int NUM_CHANNELS = 2;
  typedef logic [NUM_CHANNELS-1:0] grant_t;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_BUSY  = 3'b010,
    ST_DRAIN = 3'b100
  } state_t;
endpackage

// File: rtl/axis_if.sv
// axis_if: AXI-Stream bundle with master/slave views
interface axis_if #(parameter int W = 8) ();
  localparam int K = (W + 7) / 8;
  logic [W-1:0] tdata;
  logic [K-1:0] tkeep;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic         tuser;
  modport master(output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave(input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/aes_rr_arbiter.sv
// aes_rr_arbiter: two-way round-robin pick with pointer advancing past each grantee
module aes_rr_arbiter
  import aes_arb_pkg::*;
(
  input  logic   Clk,
  input  logic   Rst,
  input  grant_t req,
  input  logic   Grant_en,
  output grant_t pick
);
  logic ptr;
  assign pick = &req ? {ptr, ~ptr} : req;
  always_ff @(posedge Clk)
    if (Rst) ptr <= 1'b0;
    else if (Grant_en) ptr <= pick[0];
endmodule

// File: rtl/aes_cbc_stream_arbiter.sv
// aes_cbc_stream_arbiter: grants one shared AES-CBC core to a channel for a whole message
module aes_cbc_stream_arbiter
  import aes_arb_pkg::*;
#(
  parameter int S_AXIS_WIDTH = 8,
  parameter int M_AXIS_WIDTH = 8
) (
  input  logic   Clk,
  input  logic   Rst,
  axis_if.slave  S0_axis,
  axis_if.slave  S1_axis,
  axis_if.master M0_axis,
  axis_if.master M1_axis,
  axis_if.master Core_s_axis,
  axis_if.slave  Core_m_axis,
  output grant_t Grant,
  output logic   Busy
);
  state_t                  state;
  grant_t                  grant_reg, req, pick;
  logic                    g0, g1, busy_st, live, in_last, out_last;
  logic [S_AXIS_WIDTH-1:0] s_data;
  logic [M_AXIS_WIDTH-1:0] m_data;
  assign req     = {S1_axis.tvalid, S0_axis.tvalid};
  assign g0      = grant_reg[0];
  assign g1      = grant_reg[1];
  assign busy_st = state == ST_BUSY;
  assign live    = state != ST_IDLE;
  assign Grant   = grant_reg;
  assign Busy    = live;
  aes_rr_arbiter u_rr (
    .Clk(Clk), .Rst(Rst), .req(req), .Grant_en(state == ST_IDLE && |req), .pick(pick)
  );
  // Request side only flows while the owner is still sending its message
  assign s_data              = g1 ? S1_axis.tdata : S0_axis.tdata;
  assign Core_s_axis.tdata   = busy_st ? s_data : '0;
  assign Core_s_axis.tkeep   = busy_st ? (g1 ? S1_axis.tkeep : S0_axis.tkeep) : '0;
  assign Core_s_axis.tvalid  = busy_st & (g1 ? S1_axis.tvalid : S0_axis.tvalid);
  assign Core_s_axis.tlast   = busy_st & (g1 ? S1_axis.tlast : S0_axis.tlast);
  assign Core_s_axis.tuser   = busy_st & (g1 ? S1_axis.tuser : S0_axis.tuser);
  assign S0_axis.tready      = busy_st & g0 & Core_s_axis.tready;
  assign S1_axis.tready      = busy_st & g1 & Core_s_axis.tready;
  // Result side stays routed through drain until the core's final beat
  assign m_data              = live ? Core_m_axis.tdata : '0;
  assign M0_axis.tdata       = g0 ? m_data : '0;
  assign M1_axis.tdata       = g1 ? m_data : '0;
  assign M0_axis.tkeep       = live & g0 ? Core_m_axis.tkeep : '0;
  assign M1_axis.tkeep       = live & g1 ? Core_m_axis.tkeep : '0;
  assign M0_axis.tvalid      = live & g0 & Core_m_axis.tvalid;
  assign M1_axis.tvalid      = live & g1 & Core_m_axis.tvalid;
  assign M0_axis.tlast       = live & g0 & Core_m_axis.tlast;
  assign M1_axis.tlast       = live & g1 & Core_m_axis.tlast;
  assign M0_axis.tuser       = live & g0 & Core_m_axis.tuser;
  assign M1_axis.tuser       = live & g1 & Core_m_axis.tuser;
  assign Core_m_axis.tready  = live & (g0 & M0_axis.tready | g1 & M1_axis.tready);
  assign in_last  = Core_s_axis.tvalid & Core_s_axis.tready & Core_s_axis.tlast;
  assign out_last = Core_m_axis.tvalid & Core_m_axis.tready & Core_m_axis.tlast;
  // Output tlast wins over a coincident input tlast
  always_ff @(posedge Clk)
    if (Rst) begin
      state     <= ST_IDLE;
      grant_reg <= '0;
    end else if (state == ST_IDLE) begin
      if (|req) begin
        state     <= ST_BUSY;
        grant_reg <= pick;
      end
    end else if (out_last) begin
      state     <= ST_IDLE;
      grant_reg <= '0;
    end else if (in_last) state <= ST_DRAIN;
endmodule

// File: tb/tb_aes_cbc_stream_arbiter.sv
// tb_aes_cbc_stream_arbiter: randomized scoreboard bench with a stand-in core
module tb_aes_cbc_stream_arbiter;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;
  logic [1:0] grant;
  logic       busy;
  axis_if #(.W(8)) s0(), s1(), m0(), m1(), cs(), cm();
  aes_cbc_stream_arbiter #(.S_AXIS_WIDTH(8), .M_AXIS_WIDTH(8)) dut (
    .Clk(Clk), .Rst(Rst), .S0_axis(s0), .S1_axis(s1), .M0_axis(m0), .M1_axis(m1),
    .Core_s_axis(cs), .Core_m_axis(cm), .Grant(grant), .Busy(busy)
  );
  logic [7:0] s_data [2];
  logic [1:0] s_valid = '0, s_last = '0, s_user = '0, m_ready = '0;
  assign s0.tdata = s_data[0];
  assign s1.tdata = s_data[1];
  assign {s1.tkeep, s0.tkeep} = 2'b11;
  assign {s1.tvalid, s0.tvalid} = s_valid;
  assign {s1.tlast, s0.tlast} = s_last;
  assign {s1.tuser, s0.tuser} = s_user;
  assign {m1.tready, m0.tready} = m_ready;
  logic [1:0] s_ready, m_valid, m_last, m_user, m_keep;
  logic [7:0] m_data [2];
  assign s_ready = {s1.tready, s0.tready};
  assign m_valid = {m1.tvalid, m0.tvalid};
  assign m_last  = {m1.tlast, m0.tlast};
  assign m_user  = {m1.tuser, m0.tuser};
  assign m_keep  = {m1.tkeep, m0.tkeep};
  assign m_data[0] = m0.tdata;
  assign m_data[1] = m1.tdata;
  int vectors = 0, errors = 0;
  logic abort = 1'b0;
  logic [9:0] exp_q [2][$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Stand-in core: each word is returned as data^5A with its tlast/tuser after a random delay
  logic       core_ready = 1'b0, cv = 1'b0, cl = 1'b0, cu = 1'b0;
  logic [7:0] cd = '0;
  logic [9:0] cq [$];
  assign cs.tready = core_ready;
  assign cm.tvalid = cv;
  assign cm.tdata  = cd;
  assign cm.tlast  = cl;
  assign cm.tuser  = cu;
  assign cm.tkeep  = 1'b1;
  initial begin
    logic r, ih, oh;
    logic [9:0] iw;
    forever begin
      @(negedge Clk);
      r  = Rst;
      ih = cs.tvalid && cs.tready;
      oh = cm.tvalid && cm.tready;
      iw = {cs.tuser, cs.tlast, cs.tdata ^ 8'h5A};
      if (ih && !r) chk("core_tkeep", 32'(cs.tkeep), 32'd1);
      @(posedge Clk);
      #1;
      if (r) cq.delete();
      else begin
        if (oh) void'(cq.pop_front());
        if (ih) cq.push_back(iw);
      end
      core_ready = $urandom_range(0, 3) != 0;
      cv = cq.size() != 0 && $urandom_range(0, 3) != 0;
      {cu, cl, cd} = cv ? cq[0] : 10'h0;
    end
  end
  initial forever begin
    @(posedge Clk);
    #1;
    m_ready = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1};
  end
  // Monitor: routing, ownership and round-robin rules, plus per-channel scoreboard
  initial begin
    logic [1:0] prev_req = '0, in_done = '0, exp_g;
    logic prev_idle = 1'b1, prev_rst = 1'b1, last_gnt = 1'b1;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        last_gnt = 1'b1;
        in_done = '0;
      end else if (!prev_rst) begin
        if (prev_idle && prev_req != 0) begin
          exp_g = &prev_req ? (last_gnt ? 2'b01 : 2'b10) : prev_req;
          chk("grant_pick", 32'(grant), 32'(exp_g));
          last_gnt = exp_g[1];
        end
        chk("busy_vs_grant", 32'(busy), 32'(grant != 0));
        chk("core_m_tready", 32'(cm.tready), 32'(grant[0] ? m_ready[0] : grant[1] & m_ready[1]));
        for (int c = 0; c < 2; c++) begin
          if (s_ready[c]) begin
            chk($sformatf("s%0d_ready_owner", c), 32'(grant[c]), 32'd1);
            chk($sformatf("s%0d_ready_after_tlast", c), 32'(in_done[c]), 32'd0);
            if (s_valid[c] && s_last[c]) in_done[c] = 1'b1;
          end
          if (m_valid[c]) chk($sformatf("m%0d_valid_owner", c), 32'(grant[c]), 32'd1);
          if (m_valid[c] && m_ready[c]) begin
            chk($sformatf("m%0d_expected_beat", c), 32'(exp_q[c].size() != 0), 32'd1);
            if (exp_q[c].size() != 0)
              chk($sformatf("m%0d_beat", c), 32'({m_keep[c], m_user[c], m_last[c], m_data[c]}),
                  32'({1'b1, exp_q[c].pop_front()}));
          end
        end
        if (grant == 0) in_done = '0;
      end
      prev_rst  = Rst;
      prev_idle = !busy;
      prev_req  = s_valid;
    end
  end
  task automatic send(input int c, input int n, input bit enc, input int gap);
    logic [7:0] d;
    int t;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      exp_q[c].push_back({enc, i == n - 1, d ^ 8'h5A});
      while ($urandom_range(0, 99) < gap) begin
        s_valid[c] = 1'b0;
        @(posedge Clk);
        #1;
        if (abort) return;
      end
      s_valid[c] = 1'b1;
      s_data[c]  = d;
      s_last[c]  = i == n - 1;
      s_user[c]  = enc;
      t = 0;
      forever begin
        @(negedge Clk);
        if (abort) begin
          s_valid[c] = 1'b0;
          return;
        end
        if (s_ready[c]) break;
        if (++t > 2000) begin
          vectors++;
          errors++;
          $display("FAIL s%0d_accept_timeout: waited %0d cycles, limit 2000", c, t);
          s_valid[c] = 1'b0;
          return;
        end
      end
      @(posedge Clk);
      #1;
    end
    s_valid[c] = 1'b0;
    s_last[c]  = 1'b0;
  endtask
  task automatic wait_drain();
    int t = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || busy) && t < 5000) begin
      @(posedge Clk);
      t++;
    end
    if (t >= 5000) begin
      vectors++;
      errors++;
      $display("FAIL drain_timeout: %0d/%0d beats outstanding after %0d cycles", exp_q[0].size(), exp_q[1].size(), t);
    end
    @(posedge Clk);
    #1;
  endtask
  task automatic check_reset();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data_keep", 32'({m_data[1], m_data[0], m_keep}), 32'd0);
    chk("rst_core_s", 32'({cs.tvalid, cs.tlast, cs.tdata}), 32'd0);
    chk("rst_core_m_tready", 32'(cm.tready), 32'd0);
  endtask
  task automatic do_reset();
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_reset();
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    send(0, 10, 1'b1, 0);
    wait_drain();
    do_reset();
    fork
      send(0, 8, 1'b1, 0);
      send(1, 8, 1'b0, 0);
    join
    wait_drain();
    fork
      repeat (3) send(0, 6, 1'b1, 0);
      repeat (3) send(1, 6, 1'b0, 0);
    join
    wait_drain();
    repeat (8) begin
      fork
        send(0, $urandom_range(1, 12), 1'($urandom), 30);
        send(1, $urandom_range(1, 12), 1'($urandom), 30);
      join
    end
    wait_drain();
    fork
      send(1, 40, 1'b0, 0);
      begin
        repeat (12) @(posedge Clk);
        #1;
        Rst = 1'b1;
        abort = 1'b1;
        exp_q[0].delete();
        exp_q[1].delete();
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        check_reset();
      end
    join
    abort = 1'b0;
    @(posedge Clk);
    #1;
    send(1, 10, 1'b0, 10);
    wait_drain();
    chk("exp_q0_empty", 32'(exp_q[0].size()), 32'd0);
    chk("exp_q1_empty", 32'(exp_q[1].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
